dcpu_mem_responder: RTL and testbench

//  Bus responder for the dcpu bus: serves CPU fetch, load, store, push, pop, branch and return cycles.

---
 rtl/dcpu_pkg.sv | 19 +
 rtl/dcpu_mem_responder_if.sv | 21 ++
 rtl/dcpu_timer.sv | 75 +++++++
 rtl/dcpu_mem_responder.sv | 108 ++++++++++
 tb/tb_dcpu_mem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu memory responder:
// timer register map, CTRL bit positions and bus FSM encoding.
package dcpu_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_RELOAD = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IRQ = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/dcpu_mem_responder_if.sv
// dcpu bus: request from the CPU, data/ack back from the responder.
interface dcpu_mem_responder_if;

    logic        i_cs;
    logic        i_we;
    logic [15:0] i_addr;
    logic [15:0] i_dat;
    logic [15:0] o_dat;
    logic        o_ack;

    modport master (
        output i_cs, i_we, i_addr, i_dat,
        input  o_dat, o_ack
    );

    modport slave (
        input  i_cs, i_we, i_addr, i_dat,
        output o_dat, o_ack
    );

endinterface

// File: rtl/dcpu_timer.sv
// Four-register down-counting timer; pulses irq for one cycle on underflow.
module dcpu_timer
    import dcpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [1:0]  off,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq
);

    logic [1:0]  ctrl_q,   ctrl_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q,  count_d;
    logic        pend_q,   pend_d;
    logic        irq_q,    irq_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    // Order matters: a clear loses to a same-cycle underflow,
    // and a RELOAD write overrides the underflow reload.
    always_comb begin
        ctrl_d   = ctrl_q;
        reload_d = reload_q;
        count_d  = count_q;
        pend_d   = pend_q;
        irq_d    = 1'b0;
        if (wr && off == TMR_CTRL)
            ctrl_d = wdata[1:0];
        if (wr && off == TMR_STATUS && wdata[0])
            pend_d = 1'b0;
        if (ctrl_q[CTRL_EN]) begin
            if (count_q == 16'h0) begin
                count_d = reload_q;
                pend_d  = 1'b1;
                irq_d   = ctrl_q[CTRL_IRQ];
            end else begin
                count_d = count_q - 16'h1;
            end
        end
        if (wr && off == TMR_RELOAD) begin
            reload_d = wdata;
            count_d  = wdata;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (off)
            TMR_CTRL:   rdata = {14'h0, ctrl_q};
            TMR_RELOAD: rdata = reload_q;
            TMR_COUNT:  rdata = count_q;
            TMR_STATUS: rdata = {15'h0, pend_q};
        endcase
    end

    assign irq = irq_q;

endmodule

// File: rtl/dcpu_mem_responder.sv
// dcpu bus responder: word RAM, timer window and a catch-all that
// acks unmapped addresses, with optional wait states before the ack.
module dcpu_mem_responder
    import dcpu_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] TIMER_BASE  = 16'hFF00
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    dcpu_mem_responder_if.slave  bus,
    output logic                 o_int
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] wdat_q,  wdat_d;
    logic        we_q,    we_d;

    logic [15:0] mem [DEPTH];
    logic [15:0] rd_dat;
    logic [15:0] tmr_rdat;
    logic        acking;
    logic        hit_ram;
    logic        hit_tmr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_cs) begin
                    addr_d  = bus.i_addr;
                    wdat_d  = bus.i_dat;
                    we_d    = bus.i_we;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                // Dropping cs mid-wait abandons the transfer silently.
                if (!bus.i_cs)
                    state_d = IDLE;
                else if (cnt_q == WS_LAST)
                    state_d = ACK;
                else
                    cnt_d = cnt_q + 4'h1;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acking  = (state_q == ACK);
    assign hit_ram = ({1'b0, addr_q} < 17'(DEPTH));
    assign hit_tmr = (addr_q[15:2] == TIMER_BASE[15:2]);

    always_ff @(posedge i_clk) begin
        if (acking && we_q && hit_ram)
            mem[addr_q[AW-1:0]] <= wdat_q;
    end

    dcpu_timer u_timer (
        .clk   (i_clk),
        .reset (i_reset),
        .wr    (acking && we_q && hit_tmr),
        .off   (addr_q[1:0]),
        .wdata (wdat_q),
        .rdata (tmr_rdat),
        .irq   (o_int)
    );

    always_comb begin
        rd_dat = '0;
        if (hit_ram)
            rd_dat = mem[addr_q[AW-1:0]];
        else if (hit_tmr)
            rd_dat = tmr_rdat;
    end

    assign bus.o_ack = acking;
    assign bus.o_dat = (acking && !we_q) ? rd_dat : '0;

endmodule

// File: tb/tb_dcpu_mem_responder.sv
// Scoreboard bench: one responder with no wait states, one with three.
module tb_dcpu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3;
    logic int0, int3;

    dcpu_mem_responder_if if0 ();
    dcpu_mem_responder_if if3 ();

    dcpu_mem_responder #(
        .DEPTH       (1024),
        .WAIT_STATES (0),
        .TIMER_BASE  (16'hFF00)
    ) u_dut0 (
        .i_clk   (clk),
        .i_reset (rst0),
        .bus     (if0.slave),
        .o_int   (int0)
    );

    dcpu_mem_responder #(
        .DEPTH       (1024),
        .WAIT_STATES (3),
        .TIMER_BASE  (16'hFF00)
    ) u_dut3 (
        .i_clk   (clk),
        .i_reset (rst3),
        .bus     (if3.slave),
        .o_int   (int3)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acks0 = 0;
    int acks3 = 0;
    int ints3 = 0;
    int last_int0 = -1;
    bit per_on = 1'b0;
    logic [15:0] q0[$];
    logic [15:0] q3[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if0.o_ack) begin
            acks0++;
            if (q0.size() == 0) chk("ack0_extra", 16'h1, 16'h0);
            else chk("rd0_dat", if0.o_dat, q0.pop_front());
        end else begin
            chk("idle0_dat", if0.o_dat, 16'h0);
        end
        if (if3.o_ack) begin
            acks3++;
            if (q3.size() == 0) chk("ack3_extra", 16'h1, 16'h0);
            else chk("rd3_dat", if3.o_dat, q3.pop_front());
        end else begin
            chk("idle3_dat", if3.o_dat, 16'h0);
        end
        if (int3) ints3++;
        if (int0) begin
            if (per_on && last_int0 >= 0)
                chk("int_period", 16'(cyc - last_int0), 16'd4);
            last_int0 = cyc;
        end
    end

    task automatic drive(input int w, input logic cs, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (w == 0) begin
            if0.i_cs = cs; if0.i_we = we; if0.i_addr = a; if0.i_dat = d;
        end else begin
            if3.i_cs = cs; if3.i_we = we; if3.i_addr = a; if3.i_dat = d;
        end
    endtask

    function automatic logic ackf(input int w);
        return (w == 0) ? if0.o_ack : if3.o_ack;
    endfunction

    // Called just after a rising edge; returns just after the edge
    // that ends the ack cycle, with cs dropped.
    task automatic xfer(input int w, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp);
        int t0;
        int lat;
        bit got;
        t0  = cyc;
        lat = (w == 0) ? 1 : 4;
        got = 1'b0;
        drive(w, 1'b1, we, a, d);
        if (w == 0) q0.push_back(exp);
        else q3.push_back(exp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ackf(w)) begin
                got = 1'b1;
                break;
            end
        end
        if (got) chk("latency", 16'(cyc - t0), 16'(lat));
        else chk("ack_timeout", 16'h0, 16'h1);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t1;
        int t2;
        int i0;
        bit got;
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(3, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", {15'h0, if0.o_ack}, 16'h0);
        chk("rst_dat0", if0.o_dat, 16'h0);
        chk("rst_int0", {15'h0, int0}, 16'h0);
        chk("rst_ack3", {15'h0, if3.o_ack}, 16'h0);
        chk("rst_dat3", if3.o_dat, 16'h0);
        chk("rst_int3", {15'h0, int3}, 16'h0);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        // Basic write/read, no wait states
        xfer(0, 1'b1, 16'd5, 16'h1234, 16'h0);
        xfer(0, 1'b0, 16'd5, 16'h0, 16'h1234);

        // Three wait states, then an aborted write
        xfer(3, 1'b1, 16'd7, 16'hA5A5, 16'h0);
        xfer(3, 1'b0, 16'd7, 16'h0, 16'hA5A5);
        n = acks3;
        drive(3, 1'b1, 1'b1, 16'd7, 16'h0000);
        @(posedge clk);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_acks", 16'(acks3 - n), 16'h0);
        xfer(3, 1'b0, 16'd7, 16'h0, 16'hA5A5);

        // cs held high across two reads
        xfer(0, 1'b1, 16'd1, 16'h1111, 16'h0);
        xfer(0, 1'b1, 16'd2, 16'h2222, 16'h0);
        n  = acks0;
        t1 = 0;
        t2 = 0;
        drive(0, 1'b1, 1'b0, 16'd1, 16'h0);
        q0.push_back(16'h1111);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.o_ack) begin got = 1'b1; t1 = cyc; break; end
        end
        if (!got) chk("b2b_tmo1", 16'h0, 16'h1);
        drive(0, 1'b1, 1'b0, 16'd2, 16'h0);
        q0.push_back(16'h2222);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.o_ack) begin got = 1'b1; t2 = cyc; break; end
        end
        if (!got) chk("b2b_tmo2", 16'h0, 16'h1);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("b2b_gap", 16'(t2 - t1), 16'd2);
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_acks", 16'(acks0 - n), 16'd2);

        // Unmapped address
        xfer(0, 1'b1, 16'd0, 16'h0F0F, 16'h0);
        xfer(0, 1'b0, 16'h8000, 16'h0, 16'h0);
        xfer(0, 1'b1, 16'h8000, 16'hBEEF, 16'h0);
        xfer(0, 1'b0, 16'h8000, 16'h0, 16'h0);
        xfer(0, 1'b0, 16'd0, 16'h0, 16'h0F0F);
        xfer(0, 1'b0, 16'hFF01, 16'h0, 16'h0);

        // Timer registers and periodic interrupt
        xfer(0, 1'b1, 16'hFF01, 16'd3, 16'h0);
        xfer(0, 1'b0, 16'hFF02, 16'h0, 16'd3);
        xfer(0, 1'b1, 16'hFF02, 16'd9, 16'h0);
        xfer(0, 1'b0, 16'hFF02, 16'h0, 16'd3);
        per_on = 1'b1;
        xfer(0, 1'b1, 16'hFF00, 16'hFFFF, 16'h0);
        xfer(0, 1'b0, 16'hFF00, 16'h0, 16'd3);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (int0) begin got = 1'b1; break; end
        end
        if (!got) chk("int_tmo", 16'h0, 16'h1);
        // Commit edge of this clear lands on the next underflow edge
        @(posedge clk);
        @(posedge clk); #1;
        xfer(0, 1'b1, 16'hFF03, 16'h1, 16'h0);
        xfer(0, 1'b0, 16'hFF03, 16'h0, 16'h1);
        @(posedge clk); #1;
        xfer(0, 1'b1, 16'hFF03, 16'h1, 16'h0);
        xfer(0, 1'b0, 16'hFF03, 16'h0, 16'h0);

        // Reset during wait states
        xfer(3, 1'b1, 16'hFF01, 16'd5, 16'h0);
        xfer(3, 1'b1, 16'hFF00, 16'd3, 16'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_ints", 16'(ints3 > 0), 16'h1);
        n = acks3;
        drive(3, 1'b1, 1'b0, 16'd7, 16'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        chk("rst_mid_ack", {15'h0, if3.o_ack}, 16'h0);
        chk("rst_mid_int", {15'h0, int3}, 16'h0);
        drive(3, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        i0 = ints3;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_int", 16'(ints3 - i0), 16'h0);
        chk("rst_no_ack", 16'(acks3 - n), 16'h0);
        xfer(3, 1'b0, 16'hFF00, 16'h0, 16'h0);
        xfer(3, 1'b0, 16'hFF02, 16'h0, 16'h0);
        xfer(3, 1'b0, 16'd7, 16'h0, 16'hA5A5);

        repeat (4) @(posedge clk);
        #1;
        chk("sb0_empty", 16'(q0.size()), 16'h0);
        chk("sb3_empty", 16'(q3.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
